// File: rtl/tsn_sched_pkg.sv
// ---------------------------------------------------------------------------
// tsn_sched_pkg
// Shared definitions for the TSN frame-generator scheduler (tgm_sched).
//   state_e          : FSM encoding IDLE=0, OFFER=1, WAIT=2, GAP=3 (2-bit)
//   GAP_CYC_DEFAULT  : default guard gap after generator done (cycles)
//   clog2()          : constant-foldable ceil(log2) used for widths
// ---------------------------------------------------------------------------
package tsn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int GAP_CYC_DEFAULT = 3;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tgm_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational winner selection for tgm_sched.
//   i_req   [NUM_Q]  per-queue request vector
//   i_ptr   [QID_W]  id of the last granted queue (round-robin pointer)
//   o_qid   [QID_W]  selected queue id (0 when nothing requests)
//   o_found          at least one request is set
// Round-robin: first set bit searching upward from i_ptr+1 with wrap.
// With TGM_SCHED_STRICT_PRIO_EN defined: lowest-index requester wins and
// i_ptr is ignored.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_Q = 4,
  parameter int QID_W = 2
) (
  input  logic [NUM_Q-1:0] i_req,
  input  logic [QID_W-1:0] i_ptr,
  output logic [QID_W-1:0] o_qid,
  output logic             o_found
);

  logic             w_found;
  logic [QID_W-1:0] w_qid;

`ifdef TGM_SCHED_STRICT_PRIO_EN
  // The pointer has no meaning in strict-priority mode.
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_found = 1'b0;
    w_qid   = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (!w_found && i_req[i]) begin
        w_found = 1'b1;
        w_qid   = QID_W'(i);
      end
    end
  end
`else
  // Two ascending passes implement the wrap: first the queues above the
  // pointer, then (only if none of those request) from queue 0 upward, which
  // ends at the pointer itself so a lone requester keeps winning.
  always_comb begin
    w_found = 1'b0;
    w_qid   = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (!w_found && i_req[i] && (i > int'(i_ptr))) begin
        w_found = 1'b1;
        w_qid   = QID_W'(i);
      end
    end
    for (int i = 0; i < NUM_Q; i++) begin
      if (!w_found && i_req[i]) begin
        w_found = 1'b1;
        w_qid   = QID_W'(i);
      end
    end
  end
`endif

  assign o_found = w_found;
  assign o_qid   = w_qid;

endmodule

// File: rtl/tgm_sched.sv
// ---------------------------------------------------------------------------
// tgm_sched
// Shares one frame generator among NUM_Q token-bucket rate limiters. One
// grant is offered at a time over a valid/ready handshake; on acceptance the
// granted limiter gets a one-cycle select pulse to consume its tokens. After
// the generator reports done, a guard gap lets limiter requests refresh
// before the next arbitration.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   lau_update_finish       scheduling enabled while 1 (gates IDLE only)
//   test_stop               abort: back to IDLE, clears valid/select/count
//   in_tgm_req   [NUM_Q]    per-queue level requests
//   out_tgm_selected[NUM_Q] one-hot token-consume pulse
//   out_gen_valid           grant offered to the generator
//   out_gen_qid  [QID_W]    granted queue id, stable while valid
//   in_gen_ready            generator accepts the grant
//   in_gen_done             pulse: frame for accepted grant emitted
//   out_busy                1 whenever the FSM is not IDLE
//   out_grant_cnt[CNT_W]    accepted grants since reset or last stop
//
// Build option: TGM_SCHED_STRICT_PRIO_EN selects fixed priority (queue 0
// highest) instead of round-robin; the pointer is then frozen.
// QID_W must equal clog2(NUM_Q).
// ---------------------------------------------------------------------------
module tgm_sched
  import tsn_sched_pkg::*;
#(
  parameter int NUM_Q   = 4,
  parameter int QID_W   = 2,
  parameter int GAP_CYC = GAP_CYC_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lau_update_finish,
  input  logic             test_stop,
  input  logic [NUM_Q-1:0] in_tgm_req,
  output logic [NUM_Q-1:0] out_tgm_selected,
  output logic             out_gen_valid,
  output logic [QID_W-1:0] out_gen_qid,
  input  logic             in_gen_ready,
  input  logic             in_gen_done,
  output logic             out_busy,
  output logic [CNT_W-1:0] out_grant_cnt
);

  localparam int GAP_W = clog2(GAP_CYC) + 1;

  state_e           r_state;
  logic             r_gen_valid;
  logic [QID_W-1:0] r_gen_qid;
  logic [NUM_Q-1:0] r_sel;
  logic [QID_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_busy;

  state_e           w_nxt_state;
  logic             w_nxt_valid;
  logic [QID_W-1:0] w_nxt_qid;
  logic [NUM_Q-1:0] w_nxt_sel;
  logic [QID_W-1:0] w_nxt_ptr;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [GAP_W-1:0] w_nxt_gap;

  logic [QID_W-1:0] w_win_qid;
  logic             w_win_found;

  rr_arbiter #(
    .NUM_Q (NUM_Q),
    .QID_W (QID_W)
  ) u_arb (
    .i_req   (in_tgm_req),
    .i_ptr   (r_ptr),
    .o_qid   (w_win_qid),
    .o_found (w_win_found)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_gen_valid;
    w_nxt_qid   = r_gen_qid;
    w_nxt_sel   = '0;           // select is a pulse: low unless set below
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_gap   = r_gap;

    if (test_stop) begin
      // Stop beats everything, including a same-cycle ready; pointer is kept.
      w_nxt_state = IDLE;
      w_nxt_valid = 1'b0;
      w_nxt_qid   = '0;
      w_nxt_cnt   = '0;
      w_nxt_gap   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (lau_update_finish && w_win_found) begin
            w_nxt_qid   = w_win_qid;
            w_nxt_valid = 1'b1;
            w_nxt_state = OFFER;
          end
        end
        OFFER: begin
          // The request may drop here; the limiter already qualified, so the
          // offer is held until the generator takes it.
          if (in_gen_ready) begin
            w_nxt_valid = 1'b0;
            w_nxt_sel   = NUM_Q'(1) << r_gen_qid;
            w_nxt_cnt   = r_cnt + CNT_W'(1);
`ifndef TGM_SCHED_STRICT_PRIO_EN
            w_nxt_ptr   = r_gen_qid;
`endif
            w_nxt_state = WAIT;
          end
        end
        WAIT: begin
          if (in_gen_done) begin
            w_nxt_gap   = GAP_W'(GAP_CYC - 1);
            w_nxt_state = GAP;
          end
        end
        GAP: begin
          // Leave when the decrement reaches 0: GAP_CYC-1 cycles here plus
          // the IDLE arbitration cycle give GAP_CYC idle cycles after done.
          if (r_gap <= GAP_W'(1)) begin
            w_nxt_gap   = '0;
            w_nxt_state = IDLE;
          end else begin
            w_nxt_gap   = r_gap - GAP_W'(1);
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gen_valid <= 1'b0;
      r_gen_qid   <= '0;
      r_sel       <= '0;
      r_ptr       <= QID_W'(NUM_Q - 1);   // queue 0 wins the first round
      r_cnt       <= '0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_state     <= w_nxt_state;
      r_gen_valid <= w_nxt_valid;
      r_gen_qid   <= w_nxt_qid;
      r_sel       <= w_nxt_sel;
      r_ptr       <= w_nxt_ptr;
      r_cnt       <= w_nxt_cnt;
      r_gap       <= w_nxt_gap;
      r_busy      <= (w_nxt_state != IDLE);
    end
  end

  assign out_tgm_selected = r_sel;
  assign out_gen_valid    = r_gen_valid;
  assign out_gen_qid      = r_gen_qid;
  assign out_busy         = r_busy;
  assign out_grant_cnt    = r_cnt;

endmodule

// File: tb/tb_tgm_sched.sv
// ---------------------------------------------------------------------------
// tb_tgm_sched
// Self-checking bench for tgm_sched (NUM_Q=4, GAP_CYC=3). Stimulus pushes the
// expected {qid, count} of every grant it lets the generator accept; a
// monitor pops one entry per select pulse and compares. Directed checks cover
// reset, enable gating, gap timing, backpressure, stop and stop/ready
// collision. Expected grant orders follow TGM_SCHED_STRICT_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_tgm_sched;

  localparam int NUM_Q   = 4;
  localparam int QID_W   = 2;
  localparam int GAP_CYC = 3;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             lau_update_finish;
  logic             test_stop;
  logic [NUM_Q-1:0] in_tgm_req;
  logic [NUM_Q-1:0] out_tgm_selected;
  logic             out_gen_valid;
  logic [QID_W-1:0] out_gen_qid;
  logic             in_gen_ready;
  logic             in_gen_done;
  logic             out_busy;
  logic [CNT_W-1:0] out_grant_cnt;

  tgm_sched #(
    .NUM_Q   (NUM_Q),
    .QID_W   (QID_W),
    .GAP_CYC (GAP_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .lau_update_finish (lau_update_finish),
    .test_stop         (test_stop),
    .in_tgm_req        (in_tgm_req),
    .out_tgm_selected  (out_tgm_selected),
    .out_gen_valid     (out_gen_valid),
    .out_gen_qid       (out_gen_qid),
    .in_gen_ready      (in_gen_ready),
    .in_gen_done       (in_gen_done),
    .out_busy          (out_busy),
    .out_grant_cnt     (out_grant_cnt)
  );

  always #5 clk = ~clk;

  // Hand-computed grant orders.
`ifdef TGM_SCHED_STRICT_PRIO_EN
  int rr_seq[6]   = '{0, 0, 0, 0, 0, 0};   // req=1011
  int stop_next   = 0;                     // req=1011 after stop
  int tail_seq[3] = '{1, 1, 1};            // req=1110
`else
  int rr_seq[6]   = '{0, 1, 3, 0, 1, 3};
  int stop_next   = 3;                     // pointer kept at 1
  int tail_seq[3] = '{1, 2, 3};            // pointer at 0
`endif

  typedef struct {
    int qid;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for an offer; n returns the cycles waited.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!out_gen_valid && n < max) begin
      tick();
      n++;
    end
    check("offer_timeout", out_gen_valid, 1);
  endtask

  // Wait for the offer, hold ready low rdy_wait cycles, then accept it.
  task automatic grant_start(input int q, input int rdy_wait);
    int   n;
    exp_t e;
    wait_valid(40, n);
    check("offer_qid", out_gen_qid, q);
    for (int i = 0; i < rdy_wait; i++) begin
      tick();
      check("bp_valid", out_gen_valid, 1);
      check("bp_qid", out_gen_qid, q);
      check("bp_sel", out_tgm_selected, 0);
    end
    exp_cnt++;
    e.qid = q;
    e.cnt = exp_cnt;
    sb.push_back(e);
    in_gen_ready = 1'b1;
    tick();
    in_gen_ready = 1'b0;
    check("accept_valid_drop", out_gen_valid, 0);
    check("accept_busy", out_busy, 1);
  endtask

  task automatic grant_finish(input int dly);
    tick(dly);
    in_gen_done = 1'b1;
    tick();
    in_gen_done = 1'b0;
  endtask

  // Monitor: every select pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (rst_n && out_tgm_selected != '0) begin
      if (sb.size() == 0) begin
        check("sel_unexpected", 64'(out_tgm_selected), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sel_onehot", 64'(out_tgm_selected), 64'(1) << e.qid);
        check("sel_cnt", 64'(out_grant_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n             = 1'b0;
    lau_update_finish = 1'b0;
    test_stop         = 1'b0;
    in_tgm_req        = '0;
    in_gen_ready      = 1'b0;
    in_gen_done       = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_gen_valid, 0);
    check("rst_busy", out_busy, 0);
    check("rst_cnt", out_grant_cnt, 0);
    check("rst_sel", out_tgm_selected, 0);
    check("rst_qid", out_gen_qid, 0);
    rst_n = 1'b1;

    // Scheduling disabled while table configuration is not finished.
    in_tgm_req = 4'b0001;
    tick(5);
    check("gate_valid", out_gen_valid, 0);
    check("gate_busy", out_busy, 0);

    // Round robin with req=1011 held.
    in_tgm_req        = 4'b1011;
    lau_update_finish = 1'b1;
    for (int i = 0; i < 6; i++) begin
      grant_start(rr_seq[i], 0);
      grant_finish(4);
    end
    in_tgm_req = '0;
    tick(5);
    check("rr_cnt", out_grant_cnt, 6);
    check("rr_idle_busy", out_busy, 0);

    // Single queue: gap from done to next offer is GAP_CYC+1 cycles.
    in_tgm_req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      grant_start(0, 0);
      grant_finish(4);
      if (i < 2) begin
        wait_valid(40, n);
        check("gap_cycles", n + 1, GAP_CYC + 1);
      end else begin
        in_tgm_req = '0;
      end
    end

    // Backpressure: ready low for 10 cycles after valid.
    in_tgm_req = 4'b0100;
    grant_start(2, 10);
    grant_finish(3);
    in_tgm_req = '0;

    // Stop while in WAIT.
    in_tgm_req = 4'b0010;
    grant_start(1, 0);
    tick();
    test_stop  = 1'b1;
    in_tgm_req = '0;
    tick();
    test_stop  = 1'b0;
    exp_cnt    = 0;
    check("stop_busy", out_busy, 0);
    check("stop_cnt", out_grant_cnt, 0);
    check("stop_valid", out_gen_valid, 0);
    in_gen_done = 1'b1;
    tick();
    in_gen_done = 1'b0;
    tick(3);
    check("late_done_busy", out_busy, 0);
    check("late_done_cnt", out_grant_cnt, 0);
    in_tgm_req = 4'b1011;
    grant_start(stop_next, 0);
    grant_finish(2);
    in_tgm_req = '0;

    // Stop and ready in the same cycle: stop wins.
    in_tgm_req = 4'b0001;
    wait_valid(40, n);
    check("coll_offer_qid", out_gen_qid, 0);
    test_stop    = 1'b1;
    in_gen_ready = 1'b1;
    in_tgm_req   = '0;
    tick();
    test_stop    = 1'b0;
    in_gen_ready = 1'b0;
    exp_cnt      = 0;
    check("coll_sel", out_tgm_selected, 0);
    check("coll_cnt", out_grant_cnt, 0);
    check("coll_busy", out_busy, 0);
    check("coll_valid", out_gen_valid, 0);
    tick(2);
    check("coll_sel_later", out_tgm_selected, 0);
    // Pointer was not advanced by the aborted grant.
    in_tgm_req = 4'b1011;
    grant_start(0, 0);
    grant_finish(2);

    // req=1110: strict priority keeps granting queue 1.
    in_tgm_req = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      grant_start(tail_seq[i], 0);
      grant_finish(3);
    end
    in_tgm_req = '0;
    tick(6);
    check("end_busy", out_busy, 0);
    check("end_cnt", out_grant_cnt, 64'(exp_cnt));
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tgm_sched.md
Name: tgm_sched

Overview:
- Round-robin scheduler sharing one frame generator among N per-queue token-bucket rate limiters.
- Collects each limiter's generation request and grants one queue at a time over a valid/ready handshake with the generator.
- Pulses the granted limiter's select line so that limiter consumes its tokens.
- Holds off re-arbitration until the generator reports completion and a guard gap elapses, so limiter requests have time to refresh.

Parameters:
- NUM_Q, 4, number of queues/limiters (2..16).
- QID_W, 2, width of queue id; must equal clog2(NUM_Q).
- GAP_CYC, 3, idle cycles after gen done before next arbitration; minimum 2, the limiter request refresh latency.
- CNT_W, 32, width of grant statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- lau_update_finish  in  1  table configuration done; scheduling enabled while 1.
- test_stop  in  1  abort/disable; overrides everything.
- in_tgm_req  in  NUM_Q  per-queue request, level, from each limiter.
- out_tgm_selected  out  NUM_Q  one-hot, one-cycle token-consume pulse to granted limiter.
- out_gen_valid  out  1  grant offered to generator.
- out_gen_qid  out  QID_W  granted queue id; stable while out_gen_valid=1.
- in_gen_ready  in  1  generator accepts grant.
- in_gen_done  in  1  one-cycle pulse: frame for accepted grant fully emitted.
- out_busy  out  1  1 in any state other than IDLE.
- out_grant_cnt  out  CNT_W  number of accepted grants since reset or last stop.

Behaviour:
- Reset values: outputs 0, state IDLE, RR pointer = NUM_Q-1 so queue 0 wins first, gap counter 0.
- All logic is posedge clk. Outputs are registered.
- en = lau_update_finish & ~test_stop.
- IDLE:
  - If en and |in_tgm_req, pick winner w = first set bit searching upward from pointer+1, with modulo wrap.
  - Register out_gen_qid=w and out_gen_valid=1 next cycle; go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - Hold valid and qid until in_gen_ready=1.
  - On the accept cycle: next cycle out_tgm_selected[w]=1 for exactly one cycle, out_gen_valid=0, pointer=w, out_grant_cnt+1 (wraps at 2^CNT_W); go to WAIT.
  - Deasserting in_tgm_req[w] during OFFER does not withdraw the grant; the limiter already qualified.
- WAIT:
  - Wait for in_gen_done, then load gap counter with GAP_CYC-1 and go to GAP.
  - in_gen_done in any other state is ignored.
- GAP: decrement the counter each cycle; at 0 go to IDLE. The earliest new grant issue is GAP_CYC+1 cycles after done.
- test_stop=1 in any state:
  - Next cycle: state IDLE, out_gen_valid=0, out_tgm_selected=0, out_grant_cnt=0.
  - The pointer is kept.
  - If in_gen_ready and test_stop arrive in the same cycle, stop wins: no select pulse and no count.
- lau_update_finish falling mid-operation does not abort an accepted grant. It only blocks new arbitration in IDLE.
- Never more than one grant outstanding. out_tgm_selected is never multi-hot.
- Unused request bits above NUM_Q do not exist; in_tgm_req is exactly NUM_Q wide.

Optional Feature:
- Macro: TGM_SCHED_STRICT_PRIO_EN.
- Defined: IDLE picks the lowest-index requesting queue (queue 0 highest priority). The pointer is not used or updated.
- Undefined: round-robin as above.
- All handshake, gap and stop behaviour is identical in both builds.

Decomposition:
- Shared package tsn_sched_pkg holds:
  - state encoding constants IDLE=0, OFFER=1, WAIT=2, GAP=3, 2-bit;
  - default GAP_CYC constant 3;
  - a function for clog2.
- One natural sub-module, rr_arbiter:
  - combinational, NUM_Q request vector plus pointer in, winner id and found flag out;
  - contains the STRICT_PRIO macro branch.
- tgm_sched itself holds the FSM, gap counter, pointer and statistics register.

Test Plan:
- Single queue:
  - Stimulus: req=0001, ready tied 1, done 4 cycles after accept.
  - Required: selected=0001 pulses once per grant; next valid exactly GAP_CYC+1 cycles after done; grant_cnt increments by 1 each time.
- Round robin:
  - Stimulus: req=1011 held.
  - Required: grant qid sequence 0,1,3,0,1,3; grant_cnt=6 after six done pulses.
- Backpressure:
  - Stimulus: ready held 0 for 10 cycles after valid.
  - Required: valid and qid stable for those 10 cycles; no selected pulse until cycle after ready=1.
- Stop mid-WAIT:
  - Stimulus: test_stop=1 for one cycle while in WAIT.
  - Required: busy=0 and grant_cnt=0 next cycle; a later done pulse is ignored; next grant continues RR from the kept pointer.
- Stop/ready collision:
  - Stimulus: test_stop=1 and ready=1 in the same cycle.
  - Required: selected stays 0; grant_cnt=0; state IDLE.
- Strict priority (macro defined):
  - Stimulus: req=1110.
  - Required: qid 1 is granted every time, repeatedly.
